niosii_system_sysid_ext: RTL
============================

// Module: niosII_system_sysid_ext
// PURPOSE
//  Parametrised system-ID/info slave on the Nios II Avalon-MM bus; successor to the fixed sysid peripheral.
//  Serves build ID, build timestamp, info word, a byte-writable scratch register and an optional uptime counter.
//  Reads are fully pipelined with a fixed READ_LATENCY and a readdatavalid strobe.
//  Boot code uses it to identify the bitstream and time-stamp events.
// PARAMETERS
//  SYSTEM_ID     32'h0000_0000  value at word 0
//  TIMESTAMP     32'd1424220532 value at word 1
//  ADDR_W        3              word-address width (3..8); words >= 8 are unmapped
//  READ_LATENCY  1              cycles from accepted read to readdatavalid (1..4)
//  UPTIME_W      48             uptime counter width (33..64)
// PORTS
//  clock          in   1       single clock; all logic on rising edge
//  reset          in   1       synchronous, active-high
//  address        in   ADDR_W  word address
//  read           in   1       read request; accepted every cycle, no waitrequest
//  write          in   1       write request; accepted every cycle
//  writedata      in   32      write data
//  byteenable     in   4       byte lanes for writes
//  readdata       out  32      read data; 0 whenever readdatavalid=0
//  readdatavalid  out  1       one-cycle strobe per accepted read
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Reset: readdata=0, readdatavalid=0,
//   scratch=0, uptime=0, run=1, hi_shadow=0; all in-flight reads dropped.
//  Map: 0 SYSTEM_ID RO | 1 TIMESTAMP RO | 2 INFO RO = {8'(READ_LATENCY),8'(ADDR_W),8'(UPTIME_W),8'h02}
//   3 UPTIME_LO RO | 4 UPTIME_HI RO | 5 SCRATCH RW | 6 CTRL RW | 7 and >= 8: read 0, writes ignored.
//  Read: address sampled at cycle t with read=1; data = register value at t (pre-write);
//   readdatavalid=1 at t+READ_LATENCY exactly. Back-to-back reads every cycle; order preserved.
//  Write: SCRATCH updated per byteenable lane, visible to reads sampled at t+1. Writes to RO words ignored.
//  read and write in same cycle: both accepted; read returns old value.
//  Uptime: counter += 1 per cycle while CTRL.run=1; wraps 2^UPTIME_W-1 -> 0.
//   Read of UPTIME_LO returns cnt[31:0] at t and latches cnt[UPTIME_W-1:32] into hi_shadow at t.
//   Read of UPTIME_HI returns zero-extended hi_shadow (coherent 64-bit pair: LO then HI).
//  CTRL: bit0 clear (write 1: counter=0 at t+1, priority over increment; reads 0); bit1 run (reads back); others 0.
//  Reset mid-operation: pipeline flushed; no readdatavalid for reads accepted before reset.
// CONFIGURATION
//  SYSID_UPTIME_EN defined: uptime counter, hi_shadow, CTRL implemented as above.
//  SYSID_UPTIME_EN undefined: no counter logic; words 3,4,6 read 0, writes ignored; INFO[15:8]=0.
// TESTING
//  Reset, read 0 then 1 (latency 1) -> valid at t+1, t+2 with SYSTEM_ID, 32'd1424220532.
//  Write 5 = 0xA5A5A5A5 be=4'b0101, read 5 -> 0x00A500A5; write 2 = 0xFFFFFFFF -> INFO unchanged.
//  READ_LATENCY=3, reads 0,1,2,5 on 4 consecutive cycles -> 4 consecutive valid beats, same order.
//  Write CTRL=0x3 at t, read 3 at t+101 -> 100; force cnt=0x0_FFFF_FFFF, read 3 then 4 -> 0xFFFFFFFF, 0.
//  READ_LATENCY=3, 2 reads in flight, reset 1 cycle -> no readdatavalid; next read returns normally.
//  Macro undefined: read 3,4,6 -> 0; write CTRL=0x1 -> no effect; INFO = {8'd1,8'd3,8'd0,8'h02}.

Source files
------------

// File: rtl/niosii_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the extended system-ID peripheral.
// The bus master drives address/read/write/writedata/byteenable and
// receives readdata/readdatavalid.
interface niosii_system_sysid_ext_if #(
  parameter int unsigned ADDR_W = 3
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/niosii_system_sysid_ext.sv
// Extended system-ID / info slave on the Nios II Avalon-MM bus.
// Word map: 0 SYSTEM_ID, 1 TIMESTAMP, 2 INFO, 3 UPTIME_LO, 4 UPTIME_HI,
// 5 SCRATCH (byte-writable), 6 CTRL; word 7 and anything >= 8 read 0.
// Reads are pipelined with a fixed READ_LATENCY and a readdatavalid strobe.
// Optional feature macro: SYSID_UPTIME_EN adds the uptime counter, the
// coherent high-half shadow and the CTRL register. Without it, words 3, 4
// and 6 read 0 and INFO[15:8] is 0.
module niosii_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1424220532,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned UPTIME_W     = 48
) (
  input  logic                           clock,
  input  logic                           reset,
  niosii_system_sysid_ext_if.slave       bus
);

  localparam logic [2:0] WordSysId  = 3'd0;
  localparam logic [2:0] WordStamp  = 3'd1;
  localparam logic [2:0] WordInfo   = 3'd2;
  localparam logic [2:0] WordUpLo   = 3'd3;
  localparam logic [2:0] WordUpHi   = 3'd4;
  localparam logic [2:0] WordScratch = 3'd5;
  localparam logic [2:0] WordCtrl   = 3'd6;

`ifdef SYSID_UPTIME_EN
  localparam logic [7:0] InfoUptimeW = 8'(UPTIME_W);
`else
  localparam logic [7:0] InfoUptimeW = 8'h00;
`endif

  localparam logic [31:0] InfoWord = {8'(READ_LATENCY), 8'(ADDR_W), InfoUptimeW, 8'h02};

  // Address decode
  logic [ADDR_W-1:0] addr;
  logic [2:0]        word;
  logic              mapped;
  logic              wr_scratch;

  assign addr       = bus.address;
  assign word       = addr[2:0];
  // Words at or above 8 alias nothing; upper address bits must be zero.
  assign mapped     = ((addr >> 3) == '0);
  assign wr_scratch = bus.write && mapped && (word == WordScratch);

  // Scratch register
  logic [31:0] scratch_q;
  logic [31:0] scratch_d;

  // Scratch next-state: merge enabled byte lanes of the write data
  always_comb begin
    scratch_d = scratch_q;
    if (wr_scratch) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) begin
          scratch_d[i*8 +: 8] = bus.writedata[i*8 +: 8];
        end
      end
    end
  end

  // Scratch register state
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
    end else begin
      scratch_q <= scratch_d;
    end
  end

`ifdef SYSID_UPTIME_EN
  // Uptime counter, run flag and high-half shadow
  logic [UPTIME_W-1:0]  cnt_q;
  logic [UPTIME_W-1:0]  cnt_d;
  logic                 run_q;
  logic                 run_d;
  logic [UPTIME_W-33:0] hi_shadow_q;
  logic [UPTIME_W-33:0] hi_shadow_d;
  logic                 wr_ctrl;
  logic                 rd_uplo;

  assign wr_ctrl = bus.write && mapped && (word == WordCtrl) && bus.byteenable[0];
  assign rd_uplo = bus.read && mapped && (word == WordUpLo);

  // Counter next-state: clear wins over increment; run takes effect next cycle
  always_comb begin
    cnt_d       = cnt_q;
    run_d       = run_q;
    hi_shadow_d = hi_shadow_q;
    if (run_q) begin
      cnt_d = cnt_q + UPTIME_W'(1);
    end
    if (wr_ctrl) begin
      run_d = bus.writedata[1];
      if (bus.writedata[0]) begin
        cnt_d = '0;
      end
    end
    // Freeze the upper half seen by a LO read so the following HI read is coherent
    if (rd_uplo) begin
      hi_shadow_d = cnt_q[UPTIME_W-1:32];
    end
  end

  // Uptime state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      run_q       <= 1'b1;
      hi_shadow_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  logic [31:0] up_lo_val;
  logic [31:0] up_hi_val;
  logic [31:0] ctrl_val;

  assign up_lo_val = cnt_q[31:0];
  assign up_hi_val = 32'(hi_shadow_q);
  assign ctrl_val  = {30'd0, run_q, 1'b0};
`else
  logic [31:0] up_lo_val;
  logic [31:0] up_hi_val;
  logic [31:0] ctrl_val;

  assign up_lo_val = '0;
  assign up_hi_val = '0;
  assign ctrl_val  = '0;
`endif

  // Read mux: value of the addressed word as of the sampling cycle
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (mapped) begin
      unique case (word)
        WordSysId:   rd_val = SYSTEM_ID;
        WordStamp:   rd_val = TIMESTAMP;
        WordInfo:    rd_val = InfoWord;
        WordUpLo:    rd_val = up_lo_val;
        WordUpHi:    rd_val = up_hi_val;
        WordScratch: rd_val = scratch_q;
        WordCtrl:    rd_val = ctrl_val;
        default:     rd_val = '0;
      endcase
    end
  end

  // Read pipeline: stage i holds a read accepted i+1 cycles ago
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             dat_q [READ_LATENCY];

  // Read pipeline registers; non-read slots carry zero data
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= bus.read;
      dat_q[0] <= bus.read ? rd_val : 32'd0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.readdatavalid = vld_q[READ_LATENCY-1];
  assign bus.readdata      = vld_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1] : 32'd0;

endmodule
